// File: rtl/piso_frame_tx.sv
// piso_frame_tx: framed parallel-in serial-out transmitter.
// Emits start, data LSB-first, optional even parity and stop bits.
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int BIT_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int TW = $clog2(BIT_TICKS) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [TW-1:0] TLAST = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    tick, tick_n;
  logic [BW-1:0]    bitc, bitc_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic             par, par_n;
  logic             d_n, busy_n, done_n;
  logic             tick_last;

  assign tick_last  = (tick == TLAST);
  assign load_ready = rst_n && (state == IDLE);

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      bitc       <= '0;
      sh         <= '0;
      par        <= 1'b0;
      d_out      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      bitc       <= bitc_n;
      sh         <= sh_n;
      par        <= par_n;
      d_out      <= d_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Next state; outputs derive from the next state so they are registered
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitc_n  = bitc;
    sh_n    = sh;
    par_n   = par;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          sh_n    = load_data;
          par_n   = ^load_data;
          tick_n  = '0;
          bitc_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick_last) begin
          tick_n  = '0;
          state_n = DATA;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_n = '0;
          sh_n   = sh >> 1;
          if (bitc == BLAST) begin
            bitc_n  = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      PARITY: begin
        if (tick_last) begin
          tick_n  = '0;
          state_n = STOP;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_n  = '0;
          state_n = IDLE;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    d_n = 1'b1;
    unique case (state_n)
      START:   d_n = 1'b0;
      DATA:    d_n = sh_n[0];
      PARITY:  d_n = par_n;
      default: d_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (tick_n == TLAST);
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// tb_piso_frame_tx: checks three piso_frame_tx configurations
// against a per-cycle frame model built from the bit list.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] ld  [3];
  logic       lv  [3];
  logic       d   [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       fd  [3];

  int bt_of [3] = '{1, 4, 1};
  int pe_of [3] = '{1, 1, 0};

  int errors = 0;
  int checks = 0;

  logic       exp_q [$];
  logic [0:255] cap;

  typedef struct {
    int         k;
    logic [7:0] w;
    int         par;
    int         len;
  } vec_t;
  vec_t vt [7];

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(1), .BIT_TICKS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load_data(ld[0]),
    .load_valid(lv[0]), .load_ready(rdy[0]), .d_out(d[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(1), .BIT_TICKS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .load_data(ld[1]),
    .load_valid(lv[1]), .load_ready(rdy[1]), .d_out(d[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(0), .BIT_TICKS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .load_data(ld[2]),
    .load_valid(lv[2]), .load_ready(rdy[2]), .d_out(d[2]),
    .busy(bsy[2]), .frame_done(fd[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Frame as a list of line levels, each stretched to its bit time
  function automatic void build(input int k, input logic [7:0] w);
    logic b [$];
    int ones;
    exp_q.delete();
    b.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (pe_of[k] != 0) b.push_back((ones % 2) == 1);
    b.push_back(1'b1);
    foreach (b[i])
      for (int t = 0; t < bt_of[k]; t++) exp_q.push_back(b[i]);
  endfunction

  // mode 0: quiet, 1: random noise on inputs, 2: hold valid with nxt
  task automatic run_frame(input int k, input logic [7:0] w,
                           input int mode, input logic [7:0] nxt,
                           output int len, output int par);
    int c;
    int pslot;
    build(k, w);
    pslot = 9 * bt_of[k];
    par = -1;
    chk("ready_pre", rdy[k], 1);
    ld[k] = w;
    lv[k] = 1'b1;
    @(posedge clk); #1;
    lv[k] = 1'b0;
    chk("ready_busy", rdy[k], 0);
    c = 0;
    while (bsy[k] === 1'b1 && c < 200) begin
      cap[c] = d[k];
      if (c < exp_q.size()) begin
        chk("d_out", d[k], exp_q[c]);
        chk("frame_done", fd[k], c == exp_q.size() - 1);
      end
      if (pe_of[k] != 0 && c == pslot) par = int'(d[k]);
      if (c == exp_q.size() - 1) begin
        if (mode == 2) begin
          ld[k] = nxt;
          lv[k] = 1'b1;
        end else begin
          lv[k] = 1'b0;
        end
      end else if (mode == 1) begin
        lv[k] = 1'($urandom_range(0, 1));
        ld[k] = 8'($urandom);
      end
      c++;
      @(posedge clk); #1;
    end
    len = c;
    chk("frame_len", len, exp_q.size());
    chk("idle_d", d[k], 1);
    chk("idle_rdy", rdy[k], 1);
    chk("idle_fd", fd[k], 0);
  endtask

  initial begin
    int len;
    int par;
    int k;
    logic [0:10] a5_seq;
    a5_seq = 11'b01010010101;

    vt[0] = '{0, 8'hA5, 0, 11};
    vt[1] = '{1, 8'h01, 1, 44};
    vt[2] = '{0, 8'h00, 0, 11};
    vt[3] = '{0, 8'hFF, 0, 11};
    vt[4] = '{0, 8'h80, 1, 11};
    vt[5] = '{2, 8'h80, -1, 10};
    vt[6] = '{1, 8'hFF, 0, 44};

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld[i] = 8'h00;
      lv[i] = 1'b1;
    end

    // Asynchronous reset mid-cycle while valid is high
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_d", d[0], 1);
    chk("rst_busy", bsy[0], 0);
    chk("rst_fd", fd[0], 0);
    chk("rst_rdy", rdy[0], 0);
    for (int i = 0; i < 3; i++) lv[i] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rel_rdy", rdy[i], 1);
      chk("rel_d", d[i], 1);
    end

    // Directed table
    foreach (vt[i]) begin
      run_frame(vt[i].k, vt[i].w, 0, 8'h00, len, par);
      chk("tab_len", len, vt[i].len);
      if (vt[i].par >= 0) chk("tab_par", par, vt[i].par);
      if (i == 0) chk("a5_seq", 32'(cap[0:10]), 32'(a5_seq));
    end

    // Back-to-back with valid held high across frames
    run_frame(0, 8'h3C, 2, 8'hC3, len, par);
    chk("b2b_rdy_idle", rdy[0], 1);
    run_frame(0, 8'hC3, 0, 8'h00, len, par);

    // Noise on load inputs during the frame is ignored
    run_frame(0, 8'h5A, 1, 8'h00, len, par);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_extra", bsy[0], 0);
    end

    // Reset during the 4th data bit
    ld[0] = 8'h55;
    lv[0] = 1'b1;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_pre_busy", bsy[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_d", d[0], 1);
    chk("mid_busy", bsy[0], 0);
    chk("mid_fd", fd[0], 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_rdy", rdy[0], 1);
    chk("mid_rel_fd", fd[0], 0);
    run_frame(0, 8'h0F, 0, 8'h00, len, par);
    chk("mid_0f_par", par, 0);

    // Random frames on random configurations
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 2);
      run_frame(k, 8'($urandom), $urandom_range(0, 1), 8'h00,
                len, par);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Parallel-in serial-out framing transmitter.
- Sits directly upstream of the serial shift-register stages (siso/sipo). Its serial output drives their `d` input.
- Accepts one WIDTH-bit word over a valid/ready handshake and emits a framed serial stream: start bit, data LSB-first, optional even parity, stop bit.
- Each serial bit is held for BIT_TICKS clocks.

Parameters:
- WIDTH, 8: data word width in bits (≥2).
- PARITY_EN, 1: 1 = insert even-parity bit after data; 0 = no parity bit.
- BIT_TICKS, 1: clocks per serial bit (≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word; combinational, = (state==IDLE).
- d_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the STOP bit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low regardless of clk:
  - state=IDLE, d_out=1, busy=0, frame_done=0.
  - Shift register, bit counter and tick counter = 0.
  - load_ready=1 once reset is released.
- Reset mid-frame: frame is abandoned, line returns high at once, no frame_done. The first accept after release starts a clean frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - d_out=1.
  - On a rising edge with load_valid && load_ready: capture load_data into the shift register, clear the counters, go to START.
- START:
  - d_out=0 for BIT_TICKS cycles, then go to DATA.
- DATA:
  - d_out = shift_reg[0]. Each bit is held BIT_TICKS cycles, then the register shifts right.
  - After WIDTH bits: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - d_out = XOR of the captured word (even parity: total ones in data+parity is even).
  - Held BIT_TICKS cycles, then go to STOP.
- STOP:
  - d_out=1 for BIT_TICKS cycles.
  - frame_done=1 during the final cycle of STOP only, then go to IDLE.
- Latency: first START cycle is the cycle immediately after the accepting edge.
- Frame length: (2+WIDTH+PARITY_EN)*BIT_TICKS cycles. At least 1 IDLE cycle (d_out=1, load_ready=1) separates back-to-back frames.
- Outputs d_out, busy and frame_done are registered (glitch-free).
- Input changes:
  - load_valid while busy is ignored: no capture, no queuing.
  - Changes to load_data after capture have no effect on the frame in flight.
- Counter widths: tick counter sized ceil(log2(BIT_TICKS))+1; bit counter sized ceil(log2(WIDTH))+1. Neither counter wraps mid-state.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with load_valid=1 → d_out=1, busy=0, frame_done=0 and load_ready=0 immediately, asynchronous to clk; load_ready=1 after release.
- Single frame, WIDTH=8, PARITY_EN=1, BIT_TICKS=1, load 0xA5 → d_out sequence over 11 cycles is 0,1,0,1,0,0,1,0,1,0,1. frame_done is high only in cycle 11; busy is high in cycles 1–11; IDLE follows.
- Timing, BIT_TICKS=4, load 0x01 → each bit held exactly 4 clocks; 44-cycle frame; parity bit=1.
- Parity corners:
  - 0x00 → parity bit 0.
  - 0xFF → parity bit 0.
  - 0x80 → parity bit 1.
  - With PARITY_EN=0, 0x80 → 10-bit frame with no parity slot.
- Back-to-back: hold load_valid=1 with 0x3C then 0xC3 → second word is accepted on the IDLE cycle after the first frame_done; exactly one idle-high cycle between stop and the next start; 0x3C's stop bit is not corrupted.
- Ignored inputs: toggle load_data and pulse load_valid during the DATA state of 0x5A → transmitted bits match 0x5A exactly and no extra frame starts.
- Mid-frame reset: pulse rst_n low during the 4th data bit → d_out=1 immediately, no frame_done. After release, a new load of 0x0F transmits correctly.
